// File: rtl/dc_token_pkg.sv
// -----------------------------------------------------------------------------
// dc_token_pkg
// Shared definitions for the token-based dual-clock channel.
// The writer and the matching reader end both import this package.
//
// Contents:
//   DC_TOKEN_SYNC_STAGES          flop count of the token/pointer synchronizer
//   DC_TOKEN_DEFAULT_BUFFER_WIDTH default number of slots (token width)
//   dc_token_idx_width()          width of a slot index ($clog2, never below 1)
//
// Build option:
//   DC_TOKEN_SYNC3_EN  when defined, the synchronizer uses three flops
//                      instead of two (for higher-frequency corners).
// -----------------------------------------------------------------------------
package dc_token_pkg;

`ifdef DC_TOKEN_SYNC3_EN
   localparam int DC_TOKEN_SYNC_STAGES = 3;
`else
   localparam int DC_TOKEN_SYNC_STAGES = 2;
`endif

   localparam int DC_TOKEN_DEFAULT_BUFFER_WIDTH = 8;

   // A one-slot index would otherwise be zero bits wide.
   function automatic int dc_token_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dc_token_writer_if.sv
// -----------------------------------------------------------------------------
// dc_token_writer_if
// Bundles the source-side stream and the crossing-side token/pointer signals
// of one dc_token_writer instance.
//
// Signals:
//   valid_i        payload valid (upstream -> writer)
//   data_i         payload word  (upstream -> writer)
//   ready_o        slot free     (writer -> upstream)
//   writetoken_o   per-slot toggle tokens (writer -> reader domain)
//   data_async_o   flat slot array, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   readpointer_i  per-slot read toggles, asynchronous (reader -> writer)
//   idle_o         every written slot has been consumed
//
// Modports:
//   master  the environment: upstream producer plus returning read pointer
//   slave   the writer itself
// -----------------------------------------------------------------------------
interface dc_token_writer_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_WIDTH = dc_token_pkg::DC_TOKEN_DEFAULT_BUFFER_WIDTH
);
   logic                               valid_i;
   logic [DATA_WIDTH-1:0]              data_i;
   logic                               ready_o;
   logic [BUFFER_WIDTH-1:0]            writetoken_o;
   logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o;
   logic [BUFFER_WIDTH-1:0]            readpointer_i;
   logic                               idle_o;

   modport master (
      output valid_i, data_i, readpointer_i,
      input  ready_o, writetoken_o, data_async_o, idle_o
   );

   modport slave (
      input  valid_i, data_i, readpointer_i,
      output ready_o, writetoken_o, data_async_o, idle_o
   );
endinterface

// File: rtl/dc_token_sync.sv
// -----------------------------------------------------------------------------
// dc_token_sync
// Per-bit multi-flop synchronizer for token/pointer vectors. Every bit is an
// independent toggle that changes at most once per round trip, so bitwise
// synchronization cannot produce an inconsistent multi-bit value that matters.
// Depth comes from dc_token_pkg::DC_TOKEN_SYNC_STAGES (DC_TOKEN_SYNC3_EN).
//
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high reset, clears every stage to 0
//   d_i    asynchronous input vector
//   q_o    synchronized vector (last stage)
// -----------------------------------------------------------------------------
module dc_token_sync
   import dc_token_pkg::*;
#(
   parameter int WIDTH = DC_TOKEN_DEFAULT_BUFFER_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_reg [DC_TOKEN_SYNC_STAGES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < DC_TOKEN_SYNC_STAGES; s++) begin
            stage_reg[s] <= '0;
         end
      end else begin
         stage_reg[0] <= d_i;
         for (int s = 1; s < DC_TOKEN_SYNC_STAGES; s++) begin
            stage_reg[s] <= stage_reg[s-1];
         end
      end
   end

   assign q_o = stage_reg[DC_TOKEN_SYNC_STAGES-1];

endmodule

// File: rtl/dc_token_writer.sv
// -----------------------------------------------------------------------------
// dc_token_writer
// Source end of a token-based dual-clock channel. Accepts a valid/ready stream,
// stores words in a BUFFER_WIDTH-slot register buffer and flips one toggle
// token per written slot. A slot is full while its token differs from the
// synchronized read pointer bit returned by the reader.
//
// Parameters:
//   DATA_WIDTH    payload word width
//   BUFFER_WIDTH  number of slots (= token / pointer width), at least 2
//
// Ports:
//   clk_i  source clock, rst_i synchronous active-high reset
//   bus    dc_token_writer_if.slave (stream, tokens, slot data, read pointer)
//
// Build option: DC_TOKEN_SYNC3_EN selects a three-flop read-pointer
// synchronizer (two flops otherwise).
// -----------------------------------------------------------------------------
module dc_token_writer
   import dc_token_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_WIDTH = DC_TOKEN_DEFAULT_BUFFER_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   dc_token_writer_if.slave   bus
);

   localparam int                 IDX_W    = dc_token_idx_width(BUFFER_WIDTH);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);

   logic [IDX_W-1:0]        wr_idx_reg, wr_idx_next;
   logic [BUFFER_WIDTH-1:0] token_reg, token_next;
   logic [BUFFER_WIDTH-1:0] rp_sync;
   logic                    slot_free;
   logic                    push;

   dc_token_sync #(
      .WIDTH (BUFFER_WIDTH)
   ) u_rp_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (bus.readpointer_i),
      .q_o   (rp_sync)
   );

   // Registers only: no combinational path from valid_i to ready_o.
   assign slot_free = (token_reg[wr_idx_reg] == rp_sync[wr_idx_reg]);
   assign push      = bus.valid_i && slot_free;

   always_comb begin
      token_next  = token_reg;
      wr_idx_next = wr_idx_reg;
      if (push) begin
         token_next[wr_idx_reg] = ~token_reg[wr_idx_reg];
         wr_idx_next            = (wr_idx_reg == LAST_IDX) ? '0
                                                            : wr_idx_reg + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         token_reg  <= '0;
         wr_idx_reg <= '0;
      end else begin
         token_reg  <= token_next;
         wr_idx_reg <= wr_idx_next;
      end
   end

   // Slot data is captured on the same edge that flips the slot's token; the
   // reader only looks at it after synchronizing that token, so it is stable.
   // Data is kept when the slot empties and only changes on the next write.
   generate
      for (genvar gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0] slot_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               slot_reg <= '0;
            end else if (push && (wr_idx_reg == IDX_W'(gi))) begin
               slot_reg <= bus.data_i;
            end
         end

         assign bus.data_async_o[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
      end
   endgenerate

   assign bus.ready_o      = slot_free;
   assign bus.writetoken_o = token_reg;
   assign bus.idle_o       = (token_reg == rp_sync);

endmodule

// File: tb/tb_dc_token_writer.sv
// -----------------------------------------------------------------------------
// tb_dc_token_writer
// Directed checks of dc_token_writer (BUFFER_WIDTH=8, DATA_WIDTH=32) followed
// by a long run against a modelled reader on an unrelated clock (3:7 ratio).
// -----------------------------------------------------------------------------
module tb_dc_token_writer;

`ifdef DC_TOKEN_SYNC3_EN
   localparam int N_SYNC = 3;
`else
   localparam int N_SYNC = 2;
`endif
   localparam int DW       = 32;
   localparam int BW       = 8;
   localparam int N_RANDOM = 10000;

   logic clk  = 1'b0;
   logic rclk = 1'b0;
   logic rst  = 1'b1;

   // Source clock: posedges at odd ns. Reader clock: posedges at even ns.
   initial forever #3 clk = ~clk;
   initial begin
      #1;
      forever #7 rclk = ~rclk;
   end

   dc_token_writer_if #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) bus_if ();

   dc_token_writer #(
      .DATA_WIDTH   (DW),
      .BUFFER_WIDTH (BW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if.slave)
   );

   logic [BW-1:0] rp_dir;
   logic [BW-1:0] rp_model;
   logic          reader_en;
   logic          verbose;
   int            check_cnt;
   int            pass_cnt;
   int            rd_cnt;
   logic [DW-1:0] exp_q[$];

   assign bus_if.readpointer_i = reader_en ? rp_model : rp_dir;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] slot(input int i);
      return bus_if.data_async_o[i*DW +: DW];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus_if.valid_i = 1'b0;
      rp_dir = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Called and returning at posedge+1; holds valid until the transfer edge.
   task automatic push(input logic [DW-1:0] d);
      int n = 0;
      bus_if.valid_i = 1'b1;
      bus_if.data_i  = d;
      while (!bus_if.ready_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus_if.ready_o) check("push_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus_if.valid_i = 1'b0;
      if (verbose) $display("push data=%08h token=%02h ready=%0b", d, bus_if.writetoken_o, bus_if.ready_o);
   endtask

   // Counts source edges until ready_o rises (or idle_o if want_idle).
   task automatic wait_edges(input logic want_idle, output int n);
      n = 0;
      while (((want_idle ? bus_if.idle_o : bus_if.ready_o) !== 1'b1) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Reader model: two-flop token synchronizer, in-order pops, random stalls.
   logic [BW-1:0] wt_s1, wt_s2;
   int            rd_idx;
   always @(posedge rclk) begin
      if (!reader_en) begin
         wt_s1 = '0; wt_s2 = '0; rp_model = '0; rd_idx = 0;
      end else begin
         if (wt_s2[rd_idx] != rp_model[rd_idx] && $urandom_range(3) != 0) begin
            if (exp_q.size() == 0) begin
               check("rd_underflow", 64'd1, 64'd0);
            end else begin
               check("rd_data", 64'(slot(rd_idx)), 64'(exp_q.pop_front()));
            end
            rp_model[rd_idx] = ~rp_model[rd_idx];
            rd_idx = (rd_idx + 1) % BW;
            rd_cnt++;
            if (rd_cnt % 1000 == 0) $display("reader popped %0d words", rd_cnt);
         end
         wt_s2 = wt_s1;
         wt_s1 = bus_if.writetoken_o;
      end
   end

   initial begin
      int n;
      check_cnt = 0; pass_cnt = 0; rd_cnt = 0;
      reader_en = 1'b0; verbose = 1'b1;
      rp_dir = '0;
      bus_if.valid_i = 1'b0;
      bus_if.data_i  = '0;

      // ---- reset state ----
      do_reset();
      check("rst_token", 64'(bus_if.writetoken_o), 64'h00);
      check("rst_ready", 64'(bus_if.ready_o), 64'd1);
      check("rst_idle",  64'(bus_if.idle_o), 64'd1);
      check("rst_data",  64'(bus_if.data_async_o == '0), 64'd1);

      // ---- single word ----
      push(32'hDEADBEEF);
      check("single_token", 64'(bus_if.writetoken_o), 64'h01);
      check("single_slot0", 64'(slot(0)), 64'hDEADBEEF);
      check("single_idle",  64'(bus_if.idle_o), 64'd0);
      check("single_ready", 64'(bus_if.ready_o), 64'd1);
      rp_dir = 8'h01;
      wait_edges(1'b1, n);
      check("idle_latency", 64'(n), 64'(N_SYNC));

      // ---- fill ----
      do_reset();
      for (int i = 0; i < BW; i++) push(32'(i));
      check("fill_ready", 64'(bus_if.ready_o), 64'd0);
      check("fill_token", 64'(bus_if.writetoken_o), 64'hFF);
      check("fill_idle",  64'(bus_if.idle_o), 64'd0);
      for (int i = 0; i < BW; i++) check("fill_slot", 64'(slot(i)), 64'(i));
      bus_if.valid_i = 1'b1;
      bus_if.data_i  = 32'h99999999;
      repeat (20) @(posedge clk);
      #1;
      bus_if.valid_i = 1'b0;
      check("hold_token", 64'(bus_if.writetoken_o), 64'hFF);
      check("hold_slot0", 64'(slot(0)), 64'h0);
      check("hold_ready", 64'(bus_if.ready_o), 64'd0);

      // ---- drain / wrap ----
      rp_dir[0] = 1'b1;
      wait_edges(1'b0, n);
      check("ready_latency", 64'(n), 64'(N_SYNC));
      push(32'h000000A5);
      check("wrap_slot0", 64'(slot(0)), 64'hA5);
      check("wrap_slot1", 64'(slot(1)), 64'h1);
      check("wrap_token", 64'(bus_if.writetoken_o), 64'hFE);
      check("wrap_ready", 64'(bus_if.ready_o), 64'd0);

      // ---- reset mid-operation with 5 slots full ----
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
      check("five_token", 64'(bus_if.writetoken_o), 64'h1F);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_token", 64'(bus_if.writetoken_o), 64'h00);
      check("mid_rst_ready", 64'(bus_if.ready_o), 64'd1);
      check("mid_rst_idle",  64'(bus_if.idle_o), 64'd1);
      check("mid_rst_slot0", 64'(slot(0)), 64'h0);
      rst = 1'b0;

      // ---- long run against the modelled reader ----
      do_reset();
      reader_en = 1'b1;
      verbose   = 1'b0;
      for (int i = 0; i < N_RANDOM; i++) begin
         logic [DW-1:0] d;
         d = $urandom;
         exp_q.push_back(d);
         push(d);
         if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
         end
      end
      n = 0;
      while (!(bus_if.idle_o && rd_cnt == N_RANDOM) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("run_count", 64'(rd_cnt), 64'(N_RANDOM));
      check("run_idle",  64'(bus_if.idle_o), 64'd1);
      check("run_queue", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/dc_token_writer.md
# dc_token_writer

Source (write) end of the token-based dual-clock channel carried on the SoC/cluster boundary: `*_writetoken`, data and `*_readpointer` bundles. It accepts a valid/ready stream in its own clock domain, stores words in a BUFFER_WIDTH-slot register buffer and publishes one toggle token per slot. It also consumes the asynchronous read pointer returned by the receiving end. One instance serves one AXI channel (AW, AR, W, R or B) on the initiating side of a crossing.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one payload word (packed channel fields).
- BUFFER_WIDTH, 8, number of buffer slots; also the token/pointer width; must be ≥2.

Ports:
- clk_i  in  1  source-domain clock; sole clock of the block.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  payload valid.
- data_i  in  DATA_WIDTH  payload.
- ready_o  out  1  slot free; a transfer occurs when valid_i && ready_o at a rising edge.
- writetoken_o  out  BUFFER_WIDTH  per-slot toggle tokens, registered, sent to the reader.
- data_async_o  out  BUFFER_WIDTH*DATA_WIDTH  flat slot array; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- readpointer_i  in  BUFFER_WIDTH  per-slot read toggles from the reader domain; asynchronous.
- idle_o  out  1  all written slots have been consumed by the reader.

## Operation
- Slot i is full iff writetoken_o[i] != rp_sync[i], where rp_sync is readpointer_i after the synchronizer.
- wr_idx is a local index, 0..BUFFER_WIDTH-1, and wraps from BUFFER_WIDTH-1 to 0. Writes are strictly in order.
- ready_o = (writetoken_o[wr_idx] == rp_sync[wr_idx]). It is combinational from registers only, with no path from valid_i.
- On a transfer:
  - slot[wr_idx] <= data_i.
  - writetoken_o[wr_idx] toggles.
  - wr_idx advances.
- Each event changes exactly one token bit. All BUFFER_WIDTH slots are usable, so capacity is BUFFER_WIDTH.
- Slot data is written on the same edge that toggles its token. The reader samples the data only after synchronizing that token, so the data is stable by then.
- Data registers are not cleared by a slot becoming empty. Data holds until the slot is rewritten.
- idle_o = (writetoken_o == rp_sync).
- A full buffer deasserts ready_o. valid_i held without ready_o is not an error and must not alter state.
- Reset (any cycle, including mid-transfer or full):
  - writetoken_o = 0, wr_idx = 0, sync stages = 0, data registers = 0.
  - ready_o = 1 and idle_o = 1 in the first cycle after reset.
  - The reader must be reset concurrently. Pending slots are discarded.

## Timing
- Transfer at edge t → writetoken_o toggled from t+1 (registered output).
- Reader toggle → visible in rp_sync after N source edges, where N = 2, or 3 with DC_TOKEN_SYNC3_EN. ready_o and idle_o update in the same cycle rp_sync updates.
- Sustained throughput is 1 word/cycle until BUFFER_WIDTH words are outstanding.
- Minimum turnaround on a slot, from write to the source seeing it free: reader sync + reader pop + N source cycles.
- Simultaneous write to slot k and read-toggle arrival for slot j (j≠k) are independent.
- A read toggle for the slot currently addressed by wr_idx makes ready_o rise in that cycle.

## Configuration
- DC_TOKEN_SYNC3_EN defined: three-flop synchronizer on readpointer_i, N=3, for higher-frequency corners.
- DC_TOKEN_SYNC3_EN undefined: two-flop synchronizer, N=2.
- No other behaviour differs.

## Structure
- Package dc_token_pkg:
  - DC_TOKEN_SYNC_STAGES, derived from DC_TOKEN_SYNC3_EN.
  - Default BUFFER_WIDTH.
  - An index width function for wr_idx ($clog2 with a floor of 1).
- Sub-module dc_token_sync: per-bit multi-flop synchronizer, vector width parameter, stages from the package, synchronous active-high reset to 0. The matching reader end reuses it for writetoken.

## Test plan
- Single word, BUFFER_WIDTH=8, DATA_WIDTH=32:
  - Stimulus: push 0xDEADBEEF after reset.
  - Response: writetoken_o=0x01 one cycle later; data_async_o[31:0]=0xDEADBEEF; idle_o=0.
  - Then set readpointer_i=0x01 → idle_o=1 exactly N cycles later.
- Fill:
  - Stimulus: 8 back-to-back pushes 0..7 with readpointer_i held at 0.
  - Response: ready_o drops after the 8th; writetoken_o=0xFF. A 9th valid_i held for 20 cycles causes no state change.
- Drain/wrap:
  - Stimulus: from full, toggle readpointer_i[0], then push 0xA5.
  - Response: ready_o rises N cycles after the toggle; slot 0 = 0xA5; writetoken_o=0xFE.
- Long-run randomized: model reader at an unrelated clock ratio (e.g. 3:7), 10,000 words. Response: in-order, lossless delivery; no slot overwritten while full.
- Reset mid-operation: rst_i asserted with 5 slots full → next cycle writetoken_o=0, ready_o=1, idle_o=1.
- Sync depth: with DC_TOKEN_SYNC3_EN defined, the readpointer_i → ready_o latency measures 3 cycles; without it, 2 cycles.
